i2c_bus_listener: RTL and testbench

Passive, non-driving I2C bus monitor. It samples asynchronous SCL/SDA lines in the system clock domain and detects START, repeated START and STOP conditions. It deserialises each 9-bit transfer (8 data bits plus the ACK bit) into a parallel word. Two instances, one per bus (private and main), feed the downstream I2C buffer controller with per-byte, start-of-packet and end-of-transfer strobes.

---
 rtl/i2c_bus_listener.sv | 174 +++++++++++++++++
 tb/tb_i2c_bus_listener.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_listener.sv
// Passive I2C bus monitor: synchronises and de-glitches SCL/SDA, detects
// START / repeated START / STOP, and deserialises 9-bit transfers
// (8 data bits MSB-first plus the ACK bit) into a parallel word.
module i2c_bus_listener #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sda,
   input  logic       scl,
   output logic [8:0] dec,
   output logic       ready,
   output logic       sop,
   output logic       eot
);

   localparam int RW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   // Bit 1 carries SCL, bit 0 carries SDA through identical conditioning.
   logic [1:0] raw_lines;
   logic [1:0] line_f;

   assign raw_lines = {scl, sda};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_line
         logic [SYNC_STAGES-1:0] sync_q;
         logic                   sync_out;
         logic                   cand_q;
         logic [RW-1:0]          run_q;
         logic [RW-1:0]          run_d;
         logic                   filt_q;
         logic                   filt_d;

         assign sync_out = sync_q[SYNC_STAGES-1];

         // Run length of the current synchronised value; the filtered line
         // follows only once that value has been stable for FILTER_LEN samples.
         always_comb begin
            run_d  = 1;
            filt_d = filt_q;
            if (sync_out == cand_q) begin
               run_d = (run_q == RW'(FILTER_LEN)) ? run_q : run_q + 1'b1;
            end
            if (run_d == RW'(FILTER_LEN)) begin
               filt_d = sync_out;
            end
         end

         // Synchroniser chain and filter state, all preset to the idle-bus level.
         always_ff @(posedge clk) begin
            if (rst) begin
               sync_q <= '1;
               cand_q <= 1'b1;
               run_q  <= 1;
               filt_q <= 1'b1;
            end else begin
               sync_q <= {sync_q[SYNC_STAGES-2:0], raw_lines[gi]};
               cand_q <= sync_out;
               run_q  <= run_d;
               filt_q <= filt_d;
            end
         end

         assign line_f[gi] = filt_q;
      end
   endgenerate

   logic   scl_f;
   logic   sda_f;
   logic   scl_p_q;
   logic   sda_p_q;
   logic   start_det;
   logic   stop_det;
   logic   scl_rise;

   state_t     state_q, state_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic [8:0] shift_q, shift_d;
   logic [8:0] dec_q, dec_d;
   logic       ready_q, ready_d;
   logic       sop_q, sop_d;
   logic       eot_q, eot_d;

   assign scl_f = line_f[1];
   assign sda_f = line_f[0];

   // SDA edges only count as START/STOP while SCL is steadily high, so a
   // simultaneous SCL rise is always treated as a plain data sample.
   assign start_det = sda_p_q & ~sda_f & scl_p_q & scl_f;
   assign stop_det  = ~sda_p_q & sda_f & scl_p_q & scl_f;
   assign scl_rise  = ~scl_p_q & scl_f;

   // Next-state, deserialiser and strobe decode.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      dec_d     = dec_q;
      ready_d   = 1'b0;
      sop_d     = 1'b0;
      eot_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_det) begin
               state_d   = ACTIVE;
               sop_d     = 1'b1;
               bit_cnt_d = 4'd0;
               shift_d   = 9'h000;
            end
         end
         ACTIVE: begin
            if (start_det) begin
               sop_d     = 1'b1;
               bit_cnt_d = 4'd0;
               shift_d   = 9'h000;
            end else if (stop_det) begin
               state_d   = IDLE;
               eot_d     = 1'b1;
               bit_cnt_d = 4'd0;
               shift_d   = 9'h000;
            end else if (scl_rise) begin
               shift_d = {shift_q[7:0], sda_f};
               if (bit_cnt_q == 4'd8) begin
                  dec_d     = {shift_q[7:0], sda_f};
                  ready_d   = 1'b1;
                  bit_cnt_d = 4'd0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, datapath and registered strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_p_q   <= 1'b1;
         sda_p_q   <= 1'b1;
         state_q   <= IDLE;
         bit_cnt_q <= 4'd0;
         shift_q   <= 9'h000;
         dec_q     <= 9'h000;
         ready_q   <= 1'b0;
         sop_q     <= 1'b0;
         eot_q     <= 1'b0;
      end else begin
         scl_p_q   <= scl_f;
         sda_p_q   <= sda_f;
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         dec_q     <= dec_d;
         ready_q   <= ready_d;
         sop_q     <= sop_d;
         eot_q     <= eot_d;
      end
   end

   assign dec   = dec_q;
   assign ready = ready_q;
   assign sop   = sop_q;
   assign eot   = eot_q;

endmodule

// File: tb/tb_i2c_bus_listener.sv
// Directed bench for i2c_bus_listener: table of single-byte transfers plus
// hand-written sequences for latency, multi-byte, repeated START, glitches
// and mid-transfer reset.
module tb_i2c_bus_listener;

   logic       clk = 1'b0;
   logic       rst;
   logic       sda;
   logic       scl;
   logic [8:0] dec;
   logic       ready;
   logic       sop;
   logic       eot;

   int tests  = 0;
   int failed = 0;
   int excl_err = 0;

   // Event log: 1 = sop, 2 = ready, 3 = eot
   int         ev_q[$];
   logic [8:0] dec_log[$];

   typedef struct {
      logic [7:0] data;
      logic       ack;
      logic [8:0] exp_dec;
   } vec_t;

   vec_t vecs[6];

   i2c_bus_listener #(.SYNC_STAGES(2), .FILTER_LEN(3)) dut (
      .clk   (clk),
      .rst   (rst),
      .sda   (sda),
      .scl   (scl),
      .dec   (dec),
      .ready (ready),
      .sop   (sop),
      .eot   (eot)
   );

   always #5 clk = ~clk;

   // Record strobes away from the active edge.
   always @(negedge clk) begin
      if (sop) ev_q.push_back(1);
      if (ready) begin
         ev_q.push_back(2);
         dec_log.push_back(dec);
      end
      if (eot) ev_q.push_back(3);
      if ((int'(sop) + int'(ready) + int'(eot)) > 1) excl_err++;
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic int seq_code(input int base);
      int code = 0;
      for (int i = base; i < ev_q.size(); i++) code = code * 10 + ev_q[i];
      return code;
   endfunction

   // Bus idle (both high) -> START, leaves SCL low.
   task automatic send_start();
      sda = 1'b0;
      wait_clk(20);
      scl = 1'b0;
      wait_clk(10);
   endtask

   // SCL low on entry -> repeated START, leaves SCL low.
   task automatic send_rstart();
      sda = 1'b1;
      wait_clk(10);
      scl = 1'b1;
      wait_clk(10);
      sda = 1'b0;
      wait_clk(10);
      scl = 1'b0;
      wait_clk(10);
   endtask

   // One 40-cycle SCL period, data set mid-low.
   task automatic send_bit(input logic b);
      sda = b;
      wait_clk(10);
      scl = 1'b1;
      wait_clk(20);
      scl = 1'b0;
      wait_clk(10);
   endtask

   // Bit with 1- and 2-cycle SDA glitches while SCL is high.
   task automatic send_bit_sda_glitch(input logic b);
      sda = b;
      wait_clk(10);
      scl = 1'b1;
      wait_clk(5);
      sda = ~b;
      wait_clk(1);
      sda = b;
      wait_clk(5);
      sda = ~b;
      wait_clk(2);
      sda = b;
      wait_clk(7);
      scl = 1'b0;
      wait_clk(10);
   endtask

   // Bit with a 2-cycle SCL glitch while SCL is low.
   task automatic send_bit_scl_glitch(input logic b);
      sda = b;
      wait_clk(3);
      scl = 1'b1;
      wait_clk(2);
      scl = 1'b0;
      wait_clk(5);
      scl = 1'b1;
      wait_clk(20);
      scl = 1'b0;
      wait_clk(10);
   endtask

   task automatic send_word(input logic [7:0] data, input logic ack);
      for (int i = 7; i >= 0; i--) send_bit(data[i]);
      send_bit(ack);
   endtask

   // SCL low on entry -> STOP, leaves bus idle.
   task automatic send_stop();
      sda = 1'b0;
      wait_clk(10);
      scl = 1'b1;
      wait_clk(10);
      sda = 1'b1;
      wait_clk(20);
   endtask

   initial begin
      int base;
      logic [7:0] gbyte;

      vecs[0] = '{8'hA0, 1'b0, 9'h140};
      vecs[1] = '{8'h3C, 1'b0, 9'h078};
      vecs[2] = '{8'hFF, 1'b1, 9'h1FF};
      vecs[3] = '{8'h81, 1'b0, 9'h102};
      vecs[4] = '{8'h00, 1'b1, 9'h001};
      vecs[5] = '{8'h55, 1'b0, 9'h0AA};

      rst = 1'b1;
      scl = 1'b1;
      sda = 1'b1;
      wait_clk(3);
      rst = 1'b0;
      check("reset_dec", int'(dec), 0);
      check("reset_strobes", int'({ready, sop, eot}), 0);

      // Idle bus
      wait_clk(100);
      check("idle_events", ev_q.size(), 0);
      check("idle_dec", int'(dec), 0);
      $display("[TB] idle 100 cycles dec=%h events=%0d", dec, ev_q.size());

      // START latency from raw SDA edge, then byte 0xA0 ACK and STOP
      base = ev_q.size();
      sda = 1'b0;
      wait_clk(5);
      check("sop_latency_early", int'(sop), 0);
      wait_clk(1);
      check("sop_latency", int'(sop), 1);
      wait_clk(1);
      check("sop_one_cycle", int'(sop), 0);
      wait_clk(13);
      scl = 1'b0;
      wait_clk(10);
      send_word(8'hA0, 1'b0);
      send_stop();
      wait_clk(20);
      check("a0_order", seq_code(base), 123);
      check("a0_dec", int'(dec), 'h140);
      $display("[TB] latency+0xA0 dec=%h seq=%0d", dec, seq_code(base));

      // Table of single-byte transfers
      for (int v = 0; v < 6; v++) begin
         base = ev_q.size();
         send_start();
         send_word(vecs[v].data, vecs[v].ack);
         send_stop();
         wait_clk(20);
         check($sformatf("vec%0d_order", v), seq_code(base), 123);
         check($sformatf("vec%0d_dec", v), int'(dec), int'(vecs[v].exp_dec));
         $display("[TB] vec %0d data=%h ack=%b dec=%h seq=%0d",
                  v, vecs[v].data, vecs[v].ack, dec, seq_code(base));
      end

      // Two bytes in one transfer
      base = ev_q.size();
      send_start();
      send_word(8'h3C, 1'b0);
      send_word(8'hFF, 1'b1);
      send_stop();
      wait_clk(20);
      check("two_order", seq_code(base), 1223);
      check("two_first", (dec_log.size() >= 2) ? int'(dec_log[dec_log.size()-2]) : -1, 'h078);
      check("two_second", int'(dec_log[dec_log.size()-1]), 'h1FF);
      wait_clk(50);
      check("two_hold", int'(dec), 'h1FF);
      $display("[TB] two bytes dec=%h seq=%0d", dec, seq_code(base));

      // Partial byte, repeated START, byte 0x12
      base = ev_q.size();
      send_start();
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_rstart();
      send_word(8'h12, 1'b0);
      send_stop();
      wait_clk(20);
      check("rstart_order", seq_code(base), 1123);
      check("rstart_dec", int'(dec), 'h024);
      $display("[TB] repeated start dec=%h seq=%0d", dec, seq_code(base));

      // Glitches: SDA glitches while SCL high, SCL glitches while SCL low
      base = ev_q.size();
      gbyte = 8'hA5;
      send_start();
      for (int i = 7; i >= 4; i--) send_bit_sda_glitch(gbyte[i]);
      for (int i = 3; i >= 0; i--) send_bit_scl_glitch(gbyte[i]);
      send_bit_sda_glitch(1'b0);
      send_stop();
      wait_clk(20);
      check("glitch_order", seq_code(base), 123);
      check("glitch_dec", int'(dec), 'h14A);
      $display("[TB] glitch byte dec=%h seq=%0d", dec, seq_code(base));

      // Reset midway through a byte, then a fresh transfer
      send_start();
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      base = ev_q.size();
      rst = 1'b1;
      wait_clk(1);
      rst = 1'b0;
      check("midrst_dec", int'(dec), 0);
      send_bit(1'b0);
      send_bit(1'b0);
      sda = 1'b1;
      wait_clk(10);
      scl = 1'b1;
      wait_clk(20);
      check("midrst_quiet", ev_q.size() - base, 0);
      send_start();
      send_word(8'h81, 1'b0);
      send_stop();
      wait_clk(20);
      check("midrst_order", seq_code(base), 123);
      check("midrst_dec_new", int'(dec), 'h102);
      $display("[TB] reset mid-byte then 0x81 dec=%h seq=%0d", dec, seq_code(base));

      check("strobe_exclusive", excl_err, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
